// File: rtl/vstride_agen.sv
// Strided vector address generator: fetches a stride register, then streams
// base + i*(stride << size) with a valid/ready handshake.
module vstride_agen #(
  parameter int WIDTH       = 32,
  parameter int LOG2NUMREGS = 3,
  parameter int LOG2MVL     = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [WIDTH-1:0]       cmd_base,
  input  logic [LOG2MVL:0]       cmd_vl,
  input  logic [1:0]             cmd_size,
  input  logic [LOG2NUMREGS-1:0] cmd_sreg,
  output logic [LOG2NUMREGS-1:0] stride_reg,
  output logic                   stride_en,
  input  logic [WIDTH-1:0]       stride_data,
  output logic                   addr_valid,
  input  logic                   addr_ready,
  output logic [WIDTH-1:0]       addr_out,
  output logic                   addr_last,
  input  logic                   flush,
  output logic                   done
);

  typedef enum logic [1:0] {IDLE, FETCH, RUN} state_t;

  localparam logic [LOG2MVL:0] CNT_ONE = 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] base_q, base_d;
  logic [WIDTH-1:0] off_q, off_d;
  logic [WIDTH-1:0] stride_q, stride_d;
  logic [WIDTH-1:0] inc_q, inc_d;
  logic [LOG2MVL:0] vl_q, vl_d;
  logic [LOG2MVL:0] count_q, count_d;
  logic [1:0]       size_q, size_d;
  logic             done_q, done_d;
  logic             accept;
  logic             handshake;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      base_q   <= '0;
      off_q    <= '0;
      stride_q <= '0;
      inc_q    <= '0;
      vl_q     <= '0;
      count_q  <= '0;
      size_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      off_q    <= off_d;
      stride_q <= stride_d;
      inc_q    <= inc_d;
      vl_q     <= vl_d;
      count_q  <= count_d;
      size_q   <= size_d;
      done_q   <= done_d;
    end
  end

  // Gating with reset keeps the handshake outputs quiet while reset is held.
  assign cmd_ready  = (state_q == IDLE) && !flush && !reset;
  assign stride_reg = cmd_sreg;
  assign stride_en  = cmd_ready && cmd_valid;
  assign addr_valid = (state_q == RUN);
  assign addr_last  = (state_q == RUN) && (count_q == (vl_q - CNT_ONE));
  assign addr_out   = base_q + off_q;
  assign done       = done_q;
  assign accept     = cmd_valid && cmd_ready;
  assign handshake  = addr_valid && addr_ready;

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    off_d    = off_q;
    stride_d = stride_q;
    vl_d     = vl_q;
    count_d  = count_q;
    size_d   = size_q;
    done_d   = 1'b0;

    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            base_d  = cmd_base;
            off_d   = '0;
            vl_d    = cmd_vl;
            size_d  = (cmd_size == 2'd3) ? 2'd2 : cmd_size;
            count_d = '0;
            state_d = FETCH;
          end
        end
        FETCH: begin
          stride_d = stride_data;
          if (vl_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (handshake) begin
            off_d   = off_q + inc_q;
            count_d = count_q + CNT_ONE;
            if (addr_last) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Modular shift handles negative two's-complement strides unchanged.
    inc_d = stride_d << size_d;
  end

endmodule

// File: tb/tb_vstride_agen.sv
// Directed bench for vstride_agen with a one-cycle-latency stride register model.
module tb_vstride_agen;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_base;
  logic [6:0]  cmd_vl;
  logic [1:0]  cmd_size;
  logic [2:0]  cmd_sreg;
  logic [2:0]  stride_reg;
  logic        stride_en;
  logic [31:0] stride_data;
  logic        addr_valid;
  logic        addr_ready;
  logic [31:0] addr_out;
  logic        addr_last;
  logic        flush;
  logic        done;

  logic [31:0] sregs [8];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (stride_en) stride_data <= sregs[stride_reg];
  end

  vstride_agen dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_base   (cmd_base),
    .cmd_vl     (cmd_vl),
    .cmd_size   (cmd_size),
    .cmd_sreg   (cmd_sreg),
    .stride_reg (stride_reg),
    .stride_en  (stride_en),
    .stride_data(stride_data),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready),
    .addr_out   (addr_out),
    .addr_last  (addr_last),
    .flush      (flush),
    .done       (done)
  );

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b1; flush = 1'b0; addr_ready = 1'b0;
    cmd_base = 32'h0; cmd_vl = 7'd0; cmd_size = 2'd0; cmd_sreg = 3'd0;
    #12;
    vectors++;
    if ({cmd_ready, stride_en, addr_valid, addr_last, done} !== 5'b0 || addr_out !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: rdy=%b sen=%b av=%b al=%b done=%b addr=%h, required all 0",
               cmd_ready, stride_en, addr_valid, addr_last, done, addr_out);
    end
    @(negedge clk); reset = 1'b0; cmd_valid = 1'b0; #1;
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready: got %b required 1", cmd_ready);
    end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    logic [31:0] exp_addr [4];
    exp_addr[0] = 32'h1000; exp_addr[1] = 32'h100C; exp_addr[2] = 32'h1018; exp_addr[3] = 32'h1024;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_base = 32'h1000; cmd_vl = 7'd4; cmd_size = 2'd2; cmd_sreg = 3'd2;
    addr_ready = 1'b1; #1;
    vectors++;
    if (cmd_ready !== 1'b1 || stride_en !== 1'b1 || stride_reg !== 3'd2) begin
      miscompares++;
      $display("FAIL basic_accept: rdy=%b sen=%b sreg=%0d required 1 1 2", cmd_ready, stride_en, stride_reg);
    end
    @(negedge clk); cmd_valid = 1'b0; #1;
    vectors++;
    if (addr_valid !== 1'b0 || cmd_ready !== 1'b0 || stride_en !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_fetch: av=%b rdy=%b sen=%b required 0 0 0", addr_valid, cmd_ready, stride_en);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      vectors++;
      if (addr_valid !== 1'b1 || addr_out !== exp_addr[i] || addr_last !== (i == 3)) begin
        miscompares++;
        $display("FAIL basic_addr%0d: av=%b addr=%h last=%b required 1 %h %b",
                 i, addr_valid, addr_out, addr_last, exp_addr[i], (i == 3));
      end
    end
    @(negedge clk); #1;
    vectors++;
    if (done !== 1'b1 || addr_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_done: done=%b av=%b rdy=%b required 1 0 1", done, addr_valid, cmd_ready);
    end
    @(negedge clk); #1;
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_done_pulse: done=%b required 0", done);
    end
    $display("test_basic done");
  endtask

  task automatic test_negative_stride();
    logic [31:0] exp_addr [3];
    exp_addr[0] = 32'h0000_0002; exp_addr[1] = 32'h0000_0000; exp_addr[2] = 32'hFFFF_FFFE;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_base = 32'h2; cmd_vl = 7'd3; cmd_size = 2'd1; cmd_sreg = 3'd5;
    addr_ready = 1'b1;
    @(negedge clk); cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      vectors++;
      if (addr_valid !== 1'b1 || addr_out !== exp_addr[i] || addr_last !== (i == 2)) begin
        miscompares++;
        $display("FAIL neg_addr%0d: av=%b addr=%h last=%b required 1 %h %b",
                 i, addr_valid, addr_out, addr_last, exp_addr[i], (i == 2));
      end
    end
    @(negedge clk); #1;
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL neg_done: done=%b required 1", done);
    end
    $display("test_negative_stride done");
  endtask

  task automatic test_vl_zero();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_base = 32'h8000; cmd_vl = 7'd0; cmd_size = 2'd2; cmd_sreg = 3'd2; #1;
    vectors++;
    if (stride_en !== 1'b1) begin
      miscompares++;
      $display("FAIL vl0_stride_en: got %b required 1", stride_en);
    end
    @(negedge clk); cmd_valid = 1'b0; #1;
    vectors++;
    if (stride_en !== 1'b0 || addr_valid !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL vl0_fetch: sen=%b av=%b done=%b required 0 0 0", stride_en, addr_valid, done);
    end
    @(negedge clk); #1;
    vectors++;
    if (done !== 1'b1 || addr_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL vl0_done: done=%b av=%b rdy=%b required 1 0 1", done, addr_valid, cmd_ready);
    end
    $display("test_vl_zero done");
  endtask

  task automatic test_stall();
    logic [3:0]  rdy_pat;
    logic [31:0] exp_addr [4];
    logic        exp_last [4];
    int hs;
    rdy_pat = 4'b1001;
    exp_addr[0] = 32'h2000; exp_addr[1] = 32'h2004; exp_addr[2] = 32'h2004; exp_addr[3] = 32'h2004;
    exp_last[0] = 1'b0; exp_last[1] = 1'b1; exp_last[2] = 1'b1; exp_last[3] = 1'b1;
    hs = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_base = 32'h2000; cmd_vl = 7'd2; cmd_size = 2'd0; cmd_sreg = 3'd1;
    addr_ready = 1'b0;
    @(negedge clk); cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); addr_ready = rdy_pat[3-i]; #1;
      if (addr_valid && addr_ready) hs++;
      vectors++;
      if (addr_valid !== 1'b1 || addr_out !== exp_addr[i] || addr_last !== exp_last[i]) begin
        miscompares++;
        $display("FAIL stall_cycle%0d: av=%b addr=%h last=%b required 1 %h %b",
                 i, addr_valid, addr_out, addr_last, exp_addr[i], exp_last[i]);
      end
    end
    @(negedge clk); addr_ready = 1'b1; #1;
    if (addr_valid && addr_ready) hs++;
    vectors++;
    if (hs != 2 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_handshakes: hs=%0d done=%b required 2 1", hs, done);
    end
    $display("test_stall done");
  endtask

  task automatic test_flush();
    @(negedge clk);
    cmd_valid = 1'b1; flush = 1'b1; cmd_base = 32'h3000; cmd_vl = 7'd8; cmd_size = 2'd2; cmd_sreg = 3'd3; #1;
    vectors++;
    if (cmd_ready !== 1'b0 || stride_en !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_idle: rdy=%b sen=%b required 0 0", cmd_ready, stride_en);
    end
    @(negedge clk); cmd_valid = 1'b0; flush = 1'b0; #1;
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_idle_stays: rdy=%b required 1", cmd_ready);
    end
    cmd_valid = 1'b1; addr_ready = 1'b1;
    @(negedge clk); cmd_valid = 1'b0;
    @(negedge clk); #1;
    vectors++;
    if (addr_out !== 32'h3000 || addr_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_addr0: av=%b addr=%h required 1 3000", addr_valid, addr_out);
    end
    @(negedge clk); flush = 1'b1; #1;
    vectors++;
    if (addr_out !== 32'h3004 || stride_en !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_addr1: addr=%h sen=%b required 3004 0", addr_out, stride_en);
    end
    @(negedge clk); flush = 1'b0; #1;
    vectors++;
    if (addr_valid !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_abort: av=%b done=%b rdy=%b required 0 0 1", addr_valid, done, cmd_ready);
    end
    @(negedge clk); #1;
    vectors++;
    if (done !== 1'b0 || addr_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_no_done: done=%b av=%b required 0 0", done, addr_valid);
    end
    $display("test_flush done");
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_base = 32'h4000; cmd_vl = 7'd8; cmd_size = 2'd0; cmd_sreg = 3'd2;
    addr_ready = 1'b1;
    @(negedge clk); cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    vectors++;
    if (addr_out !== 32'h4003 || addr_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_run_addr1: av=%b addr=%h required 1 4003", addr_valid, addr_out);
    end
    cmd_valid = 1'b1;
    #1 reset = 1'b1;
    #1;
    vectors++;
    if ({cmd_ready, stride_en, addr_valid, addr_last, done} !== 5'b0 || addr_out !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_run_outputs: rdy=%b sen=%b av=%b al=%b done=%b addr=%h, required all 0",
               cmd_ready, stride_en, addr_valid, addr_last, done, addr_out);
    end
    @(negedge clk); reset = 1'b0;
    cmd_valid = 1'b1; cmd_base = 32'h5000; cmd_vl = 7'd2; cmd_size = 2'd1; cmd_sreg = 3'd1; #1;
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_run_ready: rdy=%b required 1", cmd_ready);
    end
    @(negedge clk); cmd_valid = 1'b0;
    @(negedge clk); #1;
    vectors++;
    if (addr_out !== 32'h5000 || addr_last !== 1'b0 || addr_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_run_new0: av=%b addr=%h last=%b required 1 5000 0", addr_valid, addr_out, addr_last);
    end
    @(negedge clk); #1;
    vectors++;
    if (addr_out !== 32'h5008 || addr_last !== 1'b1 || addr_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_run_new1: av=%b addr=%h last=%b required 1 5008 1", addr_valid, addr_out, addr_last);
    end
    @(negedge clk); #1;
    vectors++;
    if (done !== 1'b1 || addr_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_run_done: done=%b av=%b required 1 0", done, addr_valid);
    end
    $display("test_reset_mid_run done");
  endtask

  initial begin
    sregs[0] = 32'd0;          sregs[1] = 32'd4;  sregs[2] = 32'd3;  sregs[3] = 32'd1;
    sregs[4] = 32'd16;         sregs[5] = 32'hFFFF_FFFF;
    sregs[6] = 32'd7;          sregs[7] = 32'd9;
    stride_data = 32'h0;
    test_reset();
    test_basic();
    test_negative_stride();
    test_vl_zero();
    test_stall();
    test_flush();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
